// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Purpose:
//    Central stall/flush controller for a five-stage pipeline with a
//    multi-cycle multiply/divide unit. It decides each cycle whether the PC
//    and IF/ID register advance, whether ID/EX receives a bubble, whether a
//    taken branch flushes IF/ID, and whether the back end freezes on a data
//    memory wait. It also tracks mult/div occupancy and counts stall cycles.
//
// Parameters:
//    MULT_LAT     multiply busy latency in cycles (2..255)
//    DIV_LAT      divide busy latency in cycles (2..255)
//
// Ports:
//    clk          single clock, rising edge
//    rst          synchronous active-high reset
//    mem_wait     data memory not ready; whole pipeline freezes
//    lw_hazard    load-use hazard for the ID instruction
//    br_hazard    ID branch depends on an EX-stage register write
//    br_taken_ID  branch/jump resolved taken in ID
//    md_start_ID  ID instruction is mult/div
//    md_is_div    qualifies md_start_ID: 1 = div, 0 = mult
//    hilo_use_ID  ID instruction reads HI/LO
//    pc_write     PC loads when 1
//    if_id_write  IF/ID register loads when 1
//    if_id_flush  IF/ID cleared to NOP at the next edge when 1
//    id_ex_bubble ID/EX control fields zeroed when 1
//    pipe_freeze  EX/MEM and MEM/WB hold when 1
//    md_busy      multiply/divide unit occupied
//    md_done      single-cycle pulse marking HI/LO valid
//    stall_cycles saturating count of cycles with pc_write=0
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wait,
    input  logic        lw_hazard,
    input  logic        br_hazard,
    input  logic        br_taken_ID,
    input  logic        md_start_ID,
    input  logic        md_is_div,
    input  logic        hilo_use_ID,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_freeze,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } mdState_t;

    localparam logic [7:0] multLat = 8'(MULT_LAT);
    localparam logic [7:0] divLat  = 8'(DIV_LAT);

    mdState_t   state;
    mdState_t   nextState;
    logic [7:0] mdCnt;
    logic [7:0] nextMdCnt;
    logic       mdStall;
    logic       hazardStall;
    logic       issue;

    // A new mult/div or a HI/LO read has to wait while the unit is still
    // working; ordinary data hazards stall regardless of the unit.
    assign mdStall     = (state == MD_BUSY) && (hilo_use_ID || md_start_ID);
    assign hazardStall = lw_hazard || br_hazard;

    // An instruction issues to the unit only when the cycle would otherwise
    // let the pipeline advance. Being in MD_BUSY with md_start_ID already
    // counts as a stall, so the state check is the same condition spelled out.
    assign issue = md_start_ID && !mem_wait && !mdStall && !hazardStall
                   && (state != MD_BUSY);

    // State register: holds the mult/div phase and its remaining count.
    // Reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            mdCnt <= 8'd0;
        end else begin
            state <= nextState;
            mdCnt <= nextMdCnt;
        end
    end

    // Next-state logic: a memory wait freezes everything, including the
    // countdown, so the busy window stretches by the number of frozen cycles.
    // MD_DONE lasts exactly one unfrozen cycle and can chain straight into a
    // new operation.
    always_comb begin
        nextState = state;
        nextMdCnt = mdCnt;
        if (!mem_wait) begin
            case (state)
                RUN: begin
                    if (issue) begin
                        nextState = MD_BUSY;
                        nextMdCnt = md_is_div ? divLat : multLat;
                    end
                end
                MD_BUSY: begin
                    if (mdCnt == 8'd1) begin
                        nextState = MD_DONE;
                        nextMdCnt = 8'd0;
                    end else begin
                        nextMdCnt = mdCnt - 8'd1;
                    end
                end
                MD_DONE: begin
                    if (issue) begin
                        nextState = MD_BUSY;
                        nextMdCnt = md_is_div ? divLat : multLat;
                    end else begin
                        nextState = RUN;
                    end
                end
                default: begin
                    nextState = RUN;
                    nextMdCnt = 8'd0;
                end
            endcase
        end
    end

    // Output logic: a strict priority chain. A taken branch only flushes
    // once nothing above it is stalling, so the branch stays in ID until the
    // cycle it can really redirect fetch.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (mem_wait) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (mdStall || hazardStall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (br_taken_ID) begin
            if_id_flush = 1'b1;
        end
        md_busy = (state == MD_BUSY);
        md_done = (state == MD_DONE) && !mem_wait;
    end

    // Stall counter: counts every cycle the PC is held, sticking at all-ones
    // instead of wrapping so long stalls remain visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (!pc_write && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
